// File: rtl/univ_shift_reg.sv
// Universal shift register with per-edge step operations and counted burst shifts.
// A two-state FSM runs bursts from a latched mode and step count, flagging busy and a done pulse.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter int              CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_r;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       mode_r;
  logic             busy_r;
  logic             done_r;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] din,
                                                 input logic sl,
                                                 input logic sr);
    case (op)
      M_HOLD:  apply_op = cur;
      M_LOAD:  apply_op = din;
      M_SHL:   apply_op = {cur[WIDTH-2:0], sl};
      M_SHR:   apply_op = {sr, cur[WIDTH-1:1]};
      M_ROTL:  apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  apply_op = {cur[0], cur[WIDTH-1:1]};
      M_ASR:   apply_op = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLEAR: apply_op = {WIDTH{1'b0}};
      default: apply_op = cur;
    endcase
  endfunction

  // Only the shifting/rotating modes can be run as bursts.
  function automatic logic is_shift(input logic [2:0] op);
    is_shift = (op >= M_SHL) && (op <= M_ASR);
  endfunction

  // Register contents, burst FSM, step counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= RESET_VAL;
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      mode_r  <= M_HOLD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && is_shift(mode)) begin
            mode_r  <= mode;
            cnt_r   <= count;
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            q_r    <= apply_op(mode, q_r, data, ser_in_l, ser_in_r);
            busy_r <= 1'b0;
            done_r <= start;
          end
        end
        RUN: begin
          // A zero-count burst still spends one edge in RUN, just without shifting.
          if (cnt_r == CNT_ZERO) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            q_r   <= apply_op(mode_r, q_r, data, ser_in_l, ser_in_r);
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              busy_r <= 1'b1;
              done_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign q         = q_r;
  assign ser_out_l = q_r[WIDTH-1];
  assign ser_out_r = q_r[0];
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
